multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control state machine for the multicycle RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback, and handshakes with the instruction and data memories. Drives the program counter's write enable and next-PC source select. Also drives the instruction-register, memory and register-file enables, and keeps a retired-instruction counter.

## Interface
Parameters: none. Opcode and state constants come from the shared package.

- clock  input  1  core clock; all state changes on its rising edge
- reset  input  1  synchronous, active-low reset (asserted when 0)
- opcode  input  7  inst[6:0] from the instruction register, valid from DECODE onward
- branch_taken  input  1  branch comparator result, sampled in EXECUTE
- inst_ready  input  1  instruction memory has returned data; meaningful only in FETCH
- data_ready  input  1  data memory access complete; meaningful only in MEM
- inst_read_enable  output  1  instruction fetch request
- ir_write_enable  output  1  capture the fetched word into the instruction register
- data_read_enable  output  1  load request
- data_write_enable  output  1  store request
- regfile_write_enable  output  1  write rd
- pc_write_enable  output  1  program counter update
- next_pc_select  output  2  00 = pc+4, 01 = pc+imm, 10 = (rs1+imm) & ~1, 11 = reserved (never driven)
- retired  output  1  one-cycle pulse when an instruction completes
- instret  output  32  retired-instruction count
- halted  output  1  core is stopped in TRAP

## Operation
- State register holds one of: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- All outputs except instret decode combinationally from the state register plus the ready/branch inputs.
- FETCH:
  - inst_read_enable = 1.
  - While inst_ready = 0, stay in FETCH.
  - When inst_ready = 1, assert ir_write_enable that cycle and go to DECODE.
- DECODE:
  - No enables asserted.
  - Legal opcodes (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, MISC_MEM) go to EXECUTE.
  - SYSTEM or any other value goes to TRAP.
- EXECUTE:
  - BRANCH: pc_write_enable = 1, next_pc_select = 01 if branch_taken else 00, retired; go to FETCH.
  - MISC_MEM: treated as a no-op. pc_write_enable = 1, select 00, retired; go to FETCH.
  - LOAD, STORE: go to MEM.
  - Others: go to WRITEBACK.
- MEM:
  - Assert data_read_enable (LOAD) or data_write_enable (STORE), held until data_ready = 1.
  - STORE with data_ready: pc_write_enable = 1, select 00, retired; go to FETCH.
  - LOAD with data_ready: go to WRITEBACK.
- WRITEBACK:
  - regfile_write_enable = 1, pc_write_enable = 1, retired; go to FETCH.
  - next_pc_select = 01 for JAL, 10 for JALR, 00 otherwise.
- TRAP:
  - All enables and retired are 0; halted = 1.
  - Remains in TRAP until reset.
- instret increments by 1 on each cycle where retired = 1. Wraps from 0xFFFFFFFF to 0.
- Enable rules:
  - At most one memory enable is asserted in any cycle.
  - pc_write_enable and retired always coincide.

## Timing
- Reset: while reset = 0 at a rising edge, state <= FETCH and instret <= 0.
- While reset is low, every output is 0. This holds even mid-instruction: any outstanding memory request is dropped, with no PC or register-file write.
- First cycle after release: inst_read_enable = 1.
- Latency with zero-wait memory (inst_ready and data_ready high on the first request cycle):
  - BRANCH and MISC_MEM: 3 cycles
  - ALU ops, LUI, AUIPC, JAL, JALR, STORE: 4 cycles
  - LOAD: 5 cycles
- Each wait cycle on a ready input adds one cycle.
- inst_ready outside FETCH and data_ready outside MEM are ignored.
- opcode is re-evaluated in every state from DECODE through WRITEBACK. It must stay stable from the ir_write_enable edge until the return to FETCH.

## Structure
- Shared package riscv_ctrl_pkg holds the following; INITIAL_PC stays in config.sv.
  - 7-bit opcode constants, shared with the decoder.
  - State enum typedef.
  - next_pc_select encoding constants.
- No sub-modules; a single FSM plus counter is sufficient.

## Test plan
- Reset low for 2 cycles during MEM of a store, then released → no data_write_enable while low; FETCH with inst_read_enable = 1 on the first cycle after release; instret = 0.
- OP instruction with zero-wait memory → cycles 0–3 are FETCH, DECODE, EXECUTE, WRITEBACK; regfile and pc writes with select 00 only in cycle 3; instret goes 0 → 1.
- BRANCH with branch_taken = 1, then a second BRANCH with branch_taken = 0 → pc_write_enable in cycle 2 of each, select 01 then 00.
- LOAD with data_ready delayed 3 cycles → data_read_enable held for 4 cycles; WRITEBACK then follows; total latency 8 cycles.
- JALR → in WRITEBACK, select 10 with regfile_write_enable = 1; JAL → select 01.
- opcode 0x73 (SYSTEM), then 1000 idle cycles with inst_ready toggling → halted = 1; no enables asserted; instret unchanged.
- instret preloaded near wrap via 2³² − 1 retirements (or a forced value) plus one more retirement → instret reads 0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multicycle RV32I control path: opcodes, FSM states
// and next-PC source encodings.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [1:0] NPC_PLUS4   = 2'b00;
    localparam logic [1:0] NPC_PC_IMM  = 2'b01;
    localparam logic [1:0] NPC_RS1_IMM = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WRITEBACK,
        ST_TRAP
    } state_e;

    // SYSTEM is deliberately absent: the core halts on it.
    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: sequences FETCH..WRITEBACK,
// handshakes with instruction/data memories and counts retired instructions.
module multicycle_control
    import riscv_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        inst_ready,
    input  logic        data_ready,
    output logic        inst_read_enable,
    output logic        ir_write_enable,
    output logic        data_read_enable,
    output logic        data_write_enable,
    output logic        regfile_write_enable,
    output logic        pc_write_enable,
    output logic [1:0]  next_pc_select,
    output logic        retired,
    output logic [31:0] instret,
    output logic        halted
);

    state_e      state_q, state_d;
    logic [31:0] instret_q, instret_d;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    always_comb begin
        state_d              = state_q;
        inst_read_enable     = 1'b0;
        ir_write_enable      = 1'b0;
        data_read_enable     = 1'b0;
        data_write_enable    = 1'b0;
        regfile_write_enable = 1'b0;
        pc_write_enable      = 1'b0;
        next_pc_select       = NPC_PLUS4;
        retired              = 1'b0;
        halted               = 1'b0;

        // Outputs are gated by reset so a request in flight is dropped at once.
        if (reset) begin
            case (state_q)
                ST_FETCH: begin
                    inst_read_enable = 1'b1;
                    if (inst_ready) begin
                        ir_write_enable = 1'b1;
                        state_d         = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state_d = is_legal_opcode(opcode) ? ST_EXECUTE : ST_TRAP;
                end
                ST_EXECUTE: begin
                    case (opcode)
                        OPC_BRANCH: begin
                            pc_write_enable = 1'b1;
                            next_pc_select  = branch_taken ? NPC_PC_IMM : NPC_PLUS4;
                            retired         = 1'b1;
                            state_d         = ST_FETCH;
                        end
                        OPC_MISC_MEM: begin
                            pc_write_enable = 1'b1;
                            retired         = 1'b1;
                            state_d         = ST_FETCH;
                        end
                        OPC_LOAD, OPC_STORE: state_d = ST_MEM;
                        default:             state_d = ST_WRITEBACK;
                    endcase
                end
                ST_MEM: begin
                    if (opcode == OPC_LOAD) begin
                        data_read_enable = 1'b1;
                        if (data_ready) state_d = ST_WRITEBACK;
                    end else if (opcode == OPC_STORE) begin
                        data_write_enable = 1'b1;
                        if (data_ready) begin
                            pc_write_enable = 1'b1;
                            retired         = 1'b1;
                            state_d         = ST_FETCH;
                        end
                    end else begin
                        // Opcode changed under a memory access: treat as illegal.
                        state_d = ST_TRAP;
                    end
                end
                ST_WRITEBACK: begin
                    regfile_write_enable = 1'b1;
                    pc_write_enable      = 1'b1;
                    retired              = 1'b1;
                    state_d              = ST_FETCH;
                    if (opcode == OPC_JAL)       next_pc_select = NPC_PC_IMM;
                    else if (opcode == OPC_JALR) next_pc_select = NPC_RS1_IMM;
                end
                ST_TRAP: halted = 1'b1;
                default: state_d = ST_FETCH;
            endcase
        end

        instret_d = instret_q + {31'b0, retired};
        instret   = reset ? instret_q : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle checks of the control
// vector against hand-derived values for each instruction class.
module tb_multicycle_control;
    import riscv_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        inst_ready;
    logic        data_ready;
    logic        inst_read_enable;
    logic        ir_write_enable;
    logic        data_read_enable;
    logic        data_write_enable;
    logic        regfile_write_enable;
    logic        pc_write_enable;
    logic [1:0]  next_pc_select;
    logic        retired;
    logic [31:0] instret;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_control dut (
        .clock                (clock),
        .reset                (reset),
        .opcode               (opcode),
        .branch_taken         (branch_taken),
        .inst_ready           (inst_ready),
        .data_ready           (data_ready),
        .inst_read_enable     (inst_read_enable),
        .ir_write_enable      (ir_write_enable),
        .data_read_enable     (data_read_enable),
        .data_write_enable    (data_write_enable),
        .regfile_write_enable (regfile_write_enable),
        .pc_write_enable      (pc_write_enable),
        .next_pc_select       (next_pc_select),
        .retired              (retired),
        .instret              (instret),
        .halted               (halted)
    );

    always #5 clock = ~clock;

    // {ire, irw, dre, dwe, rfw, pcw, sel[1:0], ret, hlt}
    logic [9:0] ctl;
    assign ctl = {inst_read_enable, ir_write_enable, data_read_enable, data_write_enable,
                  regfile_write_enable, pc_write_enable, next_pc_select, retired, halted};

    localparam logic [9:0] E_ZERO       = 10'b00_00_00_00_00;
    localparam logic [9:0] E_FETCH_WAIT = 10'b10_00_00_00_00;
    localparam logic [9:0] E_FETCH_GO   = 10'b11_00_00_00_00;
    localparam logic [9:0] E_LOAD       = 10'b00_10_00_00_00;
    localparam logic [9:0] E_STORE      = 10'b00_01_00_00_00;
    localparam logic [9:0] E_STORE_DONE = 10'b00_01_01_00_10;
    localparam logic [9:0] E_PC_PLUS4   = 10'b00_00_01_00_10;
    localparam logic [9:0] E_PC_IMM     = 10'b00_00_01_01_10;
    localparam logic [9:0] E_WB_PLUS4   = 10'b00_00_11_00_10;
    localparam logic [9:0] E_WB_PC_IMM  = 10'b00_00_11_01_10;
    localparam logic [9:0] E_WB_RS1_IMM = 10'b00_00_11_10_10;
    localparam logic [9:0] E_HALT       = 10'b00_00_00_00_01;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Entered at posedge+1 with inputs already set; checks the combinational
    // control vector mid-cycle, then moves to the next posedge+1.
    task automatic cyc(input string tag, input logic [9:0] exp);
        #3;
        check(tag, {22'b0, ctl}, {22'b0, exp});
        @(posedge clock);
        #1;
    endtask

    // Zero-wait instruction that passes through EXECUTE into WRITEBACK.
    task automatic run_wb(input string tag, input logic [6:0] op, input logic [9:0] exp_wb);
        opcode     = op;
        inst_ready = 1'b1;
        cyc({tag, "_fetch"}, E_FETCH_GO);
        cyc({tag, "_decode"}, E_ZERO);
        cyc({tag, "_execute"}, E_ZERO);
        cyc({tag, "_wb"}, exp_wb);
    endtask

    initial begin
        reset        = 1'b0;
        opcode       = OPC_OP;
        branch_taken = 1'b0;
        inst_ready   = 1'b1;
        data_ready   = 1'b1;
        @(posedge clock);
        #1;

        // Power-on reset: everything quiet even with ready inputs high.
        cyc("por_0", E_ZERO);
        cyc("por_1", E_ZERO);
        reset      = 1'b1;
        inst_ready = 1'b0;
        check("por_instret", instret, 32'd0);
        cyc("por_first_fetch", E_FETCH_WAIT);

        // OP, zero-wait: 4 cycles, writes only in cycle 3.
        run_wb("op", OPC_OP, E_WB_PLUS4);
        check("op_instret", instret, 32'd1);

        // BRANCH taken then not taken: retire in cycle 2.
        opcode       = OPC_BRANCH;
        branch_taken = 1'b1;
        cyc("br_t_fetch", E_FETCH_GO);
        cyc("br_t_decode", E_ZERO);
        cyc("br_t_execute", E_PC_IMM);
        branch_taken = 1'b0;
        cyc("br_n_fetch", E_FETCH_GO);
        cyc("br_n_decode", E_ZERO);
        cyc("br_n_execute", E_PC_PLUS4);
        check("br_instret", instret, 32'd3);

        // LOAD with data_ready held off 3 cycles: 8 cycles total.
        opcode     = OPC_LOAD;
        data_ready = 1'b0;
        cyc("ld_fetch", E_FETCH_GO);
        cyc("ld_decode", E_ZERO);
        cyc("ld_execute", E_ZERO);
        cyc("ld_mem_wait0", E_LOAD);
        cyc("ld_mem_wait1", E_LOAD);
        cyc("ld_mem_wait2", E_LOAD);
        data_ready = 1'b1;
        cyc("ld_mem_done", E_LOAD);
        cyc("ld_wb", E_WB_PLUS4);
        check("ld_instret", instret, 32'd4);

        // Jumps select their target in WRITEBACK.
        run_wb("jalr", OPC_JALR, E_WB_RS1_IMM);
        run_wb("jal", OPC_JAL, E_WB_PC_IMM);
        check("jump_instret", instret, 32'd6);

        // MISC_MEM after one fetch wait cycle: no-op retiring in EXECUTE.
        opcode     = OPC_MISC_MEM;
        inst_ready = 1'b0;
        cyc("fence_fetch_wait", E_FETCH_WAIT);
        inst_ready = 1'b1;
        cyc("fence_fetch", E_FETCH_GO);
        cyc("fence_decode", E_ZERO);
        cyc("fence_execute", E_PC_PLUS4);
        check("fence_instret", instret, 32'd7);

        // STORE interrupted by reset during MEM.
        opcode     = OPC_STORE;
        data_ready = 1'b0;
        cyc("st_fetch", E_FETCH_GO);
        cyc("st_decode", E_ZERO);
        cyc("st_execute", E_ZERO);
        cyc("st_mem_wait", E_STORE);
        reset = 1'b0;
        cyc("st_rst_0", E_ZERO);
        data_ready = 1'b1;
        cyc("st_rst_1", E_ZERO);
        reset      = 1'b1;
        inst_ready = 1'b0;
        check("st_rst_instret", instret, 32'd0);
        cyc("st_rst_release", E_FETCH_WAIT);

        // Zero-wait STORE retires in MEM.
        opcode     = OPC_STORE;
        inst_ready = 1'b1;
        cyc("st0_fetch", E_FETCH_GO);
        cyc("st0_decode", E_ZERO);
        cyc("st0_execute", E_ZERO);
        cyc("st0_mem", E_STORE_DONE);
        check("st0_instret", instret, 32'd1);

        // Counter wrap from a forced all-ones value.
        inst_ready = 1'b0;
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        cyc("wrap_fetch_wait", E_FETCH_WAIT);
        check("wrap_preload", instret, 32'hFFFF_FFFF);
        run_wb("wrap_op", OPC_OP, E_WB_PLUS4);
        check("wrap_instret", instret, 32'd0);

        // SYSTEM halts; ready inputs toggling must not wake it.
        opcode     = OPC_SYSTEM;
        inst_ready = 1'b1;
        cyc("sys_fetch", E_FETCH_GO);
        cyc("sys_decode", E_ZERO);
        for (int i = 0; i < 1000; i++) begin
            inst_ready   = i[0];
            data_ready   = ~i[0];
            branch_taken = i[1];
            cyc("sys_trap", E_HALT);
        end
        check("sys_instret", instret, 32'd0);

        // Reset leaves TRAP; an unknown opcode traps as well.
        reset = 1'b0;
        cyc("trap_rst", E_ZERO);
        reset      = 1'b1;
        opcode     = 7'h7F;
        inst_ready = 1'b1;
        cyc("ill_fetch", E_FETCH_GO);
        cyc("ill_decode", E_ZERO);
        cyc("ill_trap_0", E_HALT);
        cyc("ill_trap_1", E_HALT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
